// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one 8-way shared resource: decoder-ready index/enable plus one-hot grant.
// A tenure ends on release, owner request drop or hold timeout, followed by a mandatory idle cycle.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [7:0] req_i,
  input  logic       release_i,
  output logic [2:0] sel_o,
  output logic       sel_en_o,
  output logic [7:0] gnt_o,
  output logic       busy_o,
  output logic       expired_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam bit               HOLD_ON  = (MAX_HOLD != 0);

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic             sel_en_q, sel_en_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             expired_q, expired_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Requests rotated so that bit 0 is the current highest-priority requester.
  logic [7:0] req_rot;
  logic [2:0] win_off;
  logic [2:0] win_idx;
  logic       any_req;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req_i[3'(ptr_q + 3'(gi))];
    end
  endgenerate

  always_comb begin
    win_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) win_off = 3'(k);
    end
  end

  assign any_req = |req_i;
  assign win_idx = ptr_q + win_off;

  logic hold_hit;
  logic owner_req;
  logic end_tenure;

  assign owner_req  = req_i[sel_q];
  assign hold_hit   = HOLD_ON && (cnt_q == HOLD_LIM);
  assign end_tenure = release_i || !owner_req || hold_hit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    sel_en_d  = sel_en_q;
    gnt_d     = gnt_q;
    expired_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d  = ST_GRANT;
          sel_d    = win_idx;
          sel_en_d = 1'b1;
          gnt_d    = 8'd1 << win_idx;
          cnt_d    = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (end_tenure) begin
          state_d   = ST_IDLE;
          sel_en_d  = 1'b0;
          gnt_d     = 8'd0;
          ptr_d     = sel_q + 3'd1;
          cnt_d     = '0;
          // Only a pure timeout counts; a simultaneous release or drop is a normal end.
          expired_d = hold_hit && !release_i && owner_req;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_en_d = 1'b0;
        gnt_d    = 8'd0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      sel_q     <= 3'd0;
      sel_en_q  <= 1'b0;
      gnt_q     <= 8'd0;
      expired_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      sel_en_q  <= sel_en_d;
      gnt_q     <= gnt_d;
      expired_q <= expired_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel_o     = sel_q;
  assign sel_en_o  = sel_en_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = sel_en_q;
  assign expired_o = expired_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: hand-computed grant sequences, timeouts, wrap and reset cases.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic [2:0] sel;
  logic       sel_en;
  logic [7:0] gnt;
  logic       busy;
  logic       expired;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(15), .CNT_W(4)) dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .req_i    (req),
    .release_i(rel),
    .sel_o    (sel),
    .sel_en_o (sel_en),
    .gnt_o    (gnt),
    .busy_o   (busy),
    .expired_o(expired)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    logic [7:0] onehot;
    onehot = 8'd1 << idx;
    check_val({tag, ".sel"},     32'(sel),     32'(idx));
    check_val({tag, ".sel_en"},  32'(sel_en),  32'd1);
    check_val({tag, ".gnt"},     32'(gnt),     32'(onehot));
    check_val({tag, ".busy"},    32'(busy),    32'd1);
    check_val({tag, ".expired"}, 32'(expired), 32'd0);
  endtask

  task automatic expect_idle(input string tag, input logic exp_expired);
    check_val({tag, ".sel_en"},  32'(sel_en),  32'd0);
    check_val({tag, ".gnt"},     32'(gnt),     32'd0);
    check_val({tag, ".busy"},    32'(busy),    32'd0);
    check_val({tag, ".expired"}, 32'(expired), 32'(exp_expired));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    rel = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int order [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    // 1: reset values, single requester 2 for 3 cycles.
    do_reset();
    expect_idle("rst", 1'b0);
    check_val("rst.sel", 32'(sel), 32'd0);
    req = 8'h04;
    step();
    expect_grant("t1.c1", 2);
    step();
    expect_grant("t1.c2", 2);
    step();
    expect_grant("t1.c3", 2);
    req = 8'h00;
    step();
    expect_idle("t1.end", 1'b0);
    check_val("t1.sel_hold", 32'(sel), 32'd2);
    // ptr must be 3: with 2 and 3 requesting, 3 wins.
    req = 8'h0C;
    step();
    expect_grant("t1.ptr3", 3);

    // 2: all requesting, release held high (ignored in IDLE) -> strict rotation.
    do_reset();
    req = 8'hFF;
    rel = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      expect_grant($sformatf("t2.g%0d", i), order[i]);
      step();
      expect_idle($sformatf("t2.i%0d", i), 1'b0);
    end
    rel = 1'b0;

    // 3: single requester 5 times out after 15 cycles, twice; third tenure released at cycle 15.
    do_reset();
    req = 8'h20;
    for (int t = 0; t < 3; t++) begin
      step();
      for (int k = 1; k <= 15; k++) begin
        expect_grant($sformatf("t3.r%0d.c%0d", t, k), 5);
        if (t == 2 && k == 15) rel = 1'b1;
        if (k < 15) step();
      end
      step();
      expect_idle($sformatf("t3.r%0d.idle", t), (t == 2) ? 1'b0 : 1'b1);
      rel = 1'b0;
    end

    // 4: ptr=6 after tenure on 5; req 0 and 3 -> 0 then 3.
    req = 8'h09;
    step();
    expect_grant("t4.g0", 0);
    rel = 1'b1;
    step();
    expect_idle("t4.i0", 1'b0);
    rel = 1'b0;
    step();
    expect_grant("t4.g3", 3);
    rel = 1'b1;
    req = 8'h00;
    step();
    expect_idle("t4.i3", 1'b0);
    rel = 1'b0;

    // 5: reset in 4th cycle of a grant to 7 (ptr currently 4).
    req = 8'h80;
    step();
    expect_grant("t5.c1", 7);
    step();
    step();
    step();
    expect_grant("t5.c4", 7);
    rst = 1'b1;
    step();
    expect_idle("t5.rst", 1'b0);
    check_val("t5.rst.sel", 32'(sel), 32'd0);
    rst = 1'b0;
    req = 8'h81;
    step();
    expect_grant("t5.g0", 0);
    rel = 1'b1;
    req = 8'h00;
    step();
    expect_idle("t5.i0", 1'b0);
    rel = 1'b0;

    // 6: owner 1 drops with release as 2 rises; 4 never preempts.
    req = 8'h02;
    step();
    expect_grant("t6.g1", 1);
    req = 8'h12;
    step();
    expect_grant("t6.g1.nopre", 1);
    req = 8'h14;
    rel = 1'b1;
    step();
    expect_idle("t6.i1", 1'b0);
    rel = 1'b0;
    step();
    expect_grant("t6.g2", 2);
    step();
    expect_grant("t6.g2.hold", 2);
    req = 8'h10;
    step();
    expect_idle("t6.drop2", 1'b0);
    step();
    expect_grant("t6.g4", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
